// File: rtl/fifo_obi_init_pkg.sv
// Shared types and constants for the FIFO OBI writer initiator.
package fifo_obi_init_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int         OUT_W  = 3;

endpackage

// File: rtl/fifo_obi_writer_initiator_fifo.sv
// Input word buffer (fifo_v3 interface); usage_o is one bit wider than the
// pointers so a full buffer reports DEPTH rather than wrapping to zero.
module fifo_v3 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  push_eff, pop_eff;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o   = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign usage_o  = cnt_q;
  assign data_o   = mem_q[rd_ptr_q];
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (ADDR_DEPTH + 1)'(push_eff) - (ADDR_DEPTH + 1)'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fifo_obi_writer_initiator.sv
// OBI write initiator feeding the serial-link FIFO responder: buffers stream
// words and issues each as a write to a fixed address, with credit tracking.
module fifo_obi_writer_initiator
  import fifo_obi_init_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    BUF_DEPTH       = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR     = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  busy_o,
  output logic [2:0]            outstanding_o,
  output logic [31:0]           sent_cnt_o,
  output logic                  err_o
);

  localparam int UW = $clog2(BUF_DEPTH) + 1;
  localparam logic [OUT_W:0] MAX_OUT = (OUT_W + 1)'(MAX_OUTSTANDING);

  logic            full, empty, push, pop;
  logic [UW-1:0]   usage;
  logic [OUT_W-1:0] outst_q;
  logic [OUT_W:0]  out_after;
  logic            credit_ok, b2b, resp_ok, resp_err;
  logic [31:0]     sent_q;
  logic            err_q;
  state_e          state_q;
  logic [DATA_WIDTH-1:0] unused_rdata;

  assign unused_rdata = rdata_i;

  fifo_v3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) i_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (full),
    .empty_o    (empty),
    .usage_o    (usage),
    .data_i     (data_i),
    .push_i     (push),
    .data_o     (wdata_o),
    .pop_i      (pop)
  );

  assign push = valid_i & ready_o;
  assign pop  = req_o & gnt_i;

  assign credit_ok = ({1'b0, outst_q} < MAX_OUT);
  // Outstanding count as seen after this cycle's grant and response settle.
  assign out_after = {1'b0, outst_q} + (OUT_W + 1)'(1) - (OUT_W + 1)'(rvalid_i);
  assign b2b       = (usage >= UW'(2)) & enable_i & (out_after < MAX_OUT);
  assign resp_ok   = rvalid_i & (outst_q != '0);
  assign resp_err  = rvalid_i & (outst_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      outst_q <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (enable_i && !empty && credit_ok) state_q <= REQ;
        REQ:     if (gnt_i && !b2b) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      outst_q <= outst_q + OUT_W'(pop) - OUT_W'(resp_ok);
      sent_q  <= sent_q + 32'(resp_ok);
      if (resp_err) err_q <= 1'b1;
    end
  end

  assign req_o         = (state_q == REQ);
  assign ready_o       = ~full;
  assign addr_o        = TARGET_ADDR;
  assign we_o          = 1'b1;
  assign be_o          = BE_ALL;
  assign busy_o        = ~empty | req_o | (outst_q != '0);
  assign outstanding_o = outst_q;
  assign sent_cnt_o    = sent_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fifo_obi_writer_initiator.sv
// Self-checking bench: queue-based reference model plus directed and random traffic.
module tb_fifo_obi_writer_initiator;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] TADDR = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, valid = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] data = '0, rdata = '0;
  logic        ready, req, we, busy, err;
  logic [31:0] addr, wdata, sent;
  logic [3:0]  be;
  logic [2:0]  outst;

  fifo_obi_writer_initiator #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (32), .BUF_DEPTH (DEPTH),
    .MAX_OUTSTANDING (MAXO), .TARGET_ADDR (TADDR)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n), .enable_i (en), .data_i (data),
    .valid_i (valid), .ready_o (ready), .req_o (req), .gnt_i (gnt),
    .addr_o (addr), .we_o (we), .be_o (be), .wdata_o (wdata),
    .rvalid_i (rvalid), .rdata_i (rdata), .busy_o (busy),
    .outstanding_o (outst), .sent_cnt_o (sent), .err_o (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [31:0] granted[$];
  bit          m_req;
  int          m_out;
  logic [31:0] m_sent;
  bit          m_err;

  int resp_mode;  // 0 none, 1 answer next cycle, 2 random
  bit gnt_rand, stream_rand, en_rand;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req  = 0;
    m_out  = 0;
    m_sent = '0;
    m_err  = 0;
  endtask

  task automatic model_step();
    int sz;
    bit push_ok, pop_ok, good, nreq;
    if (!rst_n) return;
    sz      = mq.size();
    push_ok = valid && (sz < DEPTH);
    pop_ok  = m_req && gnt;
    good    = rvalid && (m_out > 0);
    if (!m_req)    nreq = en && (sz > 0) && (m_out < MAXO);
    else if (!gnt) nreq = 1;
    else           nreq = (sz >= 2) && en && ((m_out + 1 - int'(rvalid)) < MAXO);
    if (rvalid && m_out == 0) m_err = 1;
    m_out  = m_out + int'(pop_ok) - int'(good);
    m_sent = m_sent + 32'(good);
    if (pop_ok) begin
      granted.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (push_ok) mq.push_back(data);
    m_req = nreq;
  endtask

  task automatic auto_drive();
    if (gnt_rand) gnt = ($urandom_range(0, 9) < 6);
    if (resp_mode == 1) rvalid = (m_out > 0);
    else if (resp_mode == 2)
      rvalid = (m_out > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 199) == 0);
    if (stream_rand) begin
      valid = ($urandom_range(0, 9) < 6);
      data  = $urandom;
    end
    if (en_rand) en = ($urandom_range(0, 9) != 0);
  endtask

  task automatic compare_all();
    if (!rst_n) return;
    chk("ready", 32'(ready), 32'(mq.size() < DEPTH));
    chk("req", 32'(req), 32'(m_req));
    chk("outstanding", 32'(outst), 32'(m_out));
    chk("sent", sent, m_sent);
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'((mq.size() > 0) || m_req || (m_out > 0)));
    chk("addr", addr, TADDR);
    chk("we", 32'(we), 32'd1);
    chk("be", 32'(be), 32'hF);
    if (mq.size() > 0) chk("wdata", wdata, mq[0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
    auto_drive();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    en = 0; valid = 0; gnt = 0; rvalid = 0; data = '0;
    resp_mode = 0; gnt_rand = 0; stream_rand = 0; en_rand = 0;
    rst_n = 0;
    model_reset();
    granted.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_until_idle(input int maxc, input string name);
    int n = 0;
    while (((mq.size() > 0) || m_req || (m_out > 0)) && n < maxc) begin
      cycle();
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n < maxc), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 1: single word
    do_reset();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    en = 1; gnt = 1; resp_mode = 1;
    valid = 1; data = 32'hDEADBEEF;
    cycle();
    valid = 0;
    chk("t1_no_req_yet", 32'(req), 32'd0);
    cycle();
    chk("t1_req_high", 32'(req), 32'd1);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_addr", addr, TADDR);
    chk("t1_be", 32'(be), 32'hF);
    cycle();
    chk("t1_req_one_cycle", 32'(req), 32'd0);
    cycle();
    chk("t1_sent", sent, 32'd1);
    chk("t1_busy_drop", 32'(busy), 32'd0);

    // 2: backpressure
    do_reset();
    en = 1; gnt = 0; resp_mode = 1;
    for (int i = 0; i < 3; i++) begin
      valid = 1; data = 32'hA000_0000 + 32'(i);
      cycle();
    end
    valid = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_req_stable", 32'(req), 32'd1);
      chk("t2_wdata_stable", wdata, 32'hA000_0000);
      cycle();
    end
    gnt = 1;
    run_until_idle(40, "t2");
    chk("t2_sent", sent, 32'd3);
    chk("t2_count", 32'(granted.size()), 32'd3);
    for (int i = 0; i < 3 && i < granted.size(); i++)
      chk("t2_order", granted[i], 32'hA000_0000 + 32'(i));

    // 3: credit limit
    do_reset();
    en = 1; gnt = 1; resp_mode = 0;
    for (int i = 0; i < 4; i++) begin
      valid = 1; data = 32'hC000_0000 + 32'(i);
      cycle();
    end
    valid = 0;
    repeat (8) cycle();
    chk("t3_grants", 32'(granted.size()), 32'd2);
    chk("t3_outstanding", 32'(outst), 32'd2);
    chk("t3_req_low", 32'(req), 32'd0);
    rvalid = 1;
    cycle();
    rvalid = 0;
    repeat (6) cycle();
    chk("t3_grants_after_resp", 32'(granted.size()), 32'd3);
    chk("t3_outstanding_after", 32'(outst), 32'd2);
    chk("t3_sent", sent, 32'd1);

    // 4: buffer full
    do_reset();
    en = 1; gnt = 0; resp_mode = 1;
    for (int i = 0; i < 6; i++) begin
      valid = 1; data = 32'h100 + 32'(i);
      cycle();
    end
    valid = 0;
    chk("t4_ready_low", 32'(ready), 32'd0);
    chk("t4_accepted", 32'(mq.size()), 32'd4);
    gnt = 1;
    run_until_idle(40, "t4");
    chk("t4_ready_high", 32'(ready), 32'd1);
    chk("t4_count", 32'(granted.size()), 32'd4);
    for (int i = 0; i < 4 && i < granted.size(); i++)
      chk("t4_order", granted[i], 32'h100 + 32'(i));

    // 5: protocol error
    do_reset();
    rvalid = 1;
    cycle();
    rvalid = 0;
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_outstanding", 32'(outst), 32'd0);
    chk("t5_sent", sent, 32'd0);
    repeat (3) cycle();
    chk("t5_err_sticky", 32'(err), 32'd1);

    // 6: reset mid-operation
    do_reset();
    en = 1; gnt = 0; resp_mode = 0;
    valid = 1; data = 32'h6000_0001;
    cycle();
    data = 32'h6000_0002;
    cycle();
    valid = 0;
    cycle();
    gnt = 1;
    cycle();
    gnt = 0;
    chk("t6_pre_req", 32'(req), 32'd1);
    chk("t6_pre_out", 32'(outst), 32'd1);
    #3;
    rst_n = 0;
    model_reset();
    granted.delete();
    #1;
    chk("t6_rst_req", 32'(req), 32'd0);
    chk("t6_rst_out", 32'(outst), 32'd0);
    chk("t6_rst_sent", sent, 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    en = 1; gnt = 1; resp_mode = 1;
    valid = 1; data = 32'hDEADBEEF;
    cycle();
    valid = 0;
    run_until_idle(20, "t6");
    chk("t6_sent", sent, 32'd1);
    chk("t6_word", (granted.size() > 0) ? granted[0] : 32'h0, 32'hDEADBEEF);

    // random traffic
    do_reset();
    gnt_rand = 1; stream_rand = 1; en_rand = 1; resp_mode = 2;
    repeat (3000) cycle();
    gnt_rand = 0; stream_rand = 0; en_rand = 0;
    valid = 0; en = 1; gnt = 1; resp_mode = 1;
    run_until_idle(100, "rand");
    chk("rand_sent_total", sent, 32'(granted.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
